// File: rtl/cam_hash_arbiter.sv
// ============================================================================
// Module   : cam_hash_arbiter
// Brief    : Round-robin sharing of one registered CAM hash engine among NREQ
//            requesters, with ID tagging, flush and a show-ahead response FIFO.
//            Optional macro CAM_HASH_ARB_PRIO0_EN gives requester 0 strict
//            priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_hash_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int HW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*19-1:0]   req_key_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic                 flush_i,
    output logic [18:0]          calc_d_o,
    output logic                 calc_en_o,
    input  logic [HW-1:0]        hash_i,
    input  logic                 hash_valid_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [HW-1:0]        rsp_hash_o,
    output logic                 err_o
);

    localparam int KW   = 19;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int CW1  = CW + 1;
    localparam int IDW1 = IDW + 1;
    localparam int EW   = IDW + HW;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [NREQ-1:0] REQ0_BIT = {{(NREQ-1){1'b0}}, 1'b1};

    logic [0:0]      state;
    logic [IDW-1:0]  ptr;

    logic            iss_valid;
    logic [IDW-1:0]  iss_id;
    logic [KW-1:0]   calc_d;

    logic            tag_valid;
    logic            tag_kill;
    logic [IDW-1:0]  tag_id;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            err;
    logic            after_rst;

    logic [1:0]      inflight;
    logic [CW:0]     occupancy;
    logic            space;
    logic            fifo_empty;
    logic            flush_eff;
    logic            allow;

    logic [NREQ-1:0] rr_valid;
    logic            prio_hit;
    logic            rr_found;
    logic [IDW-1:0]  rr_idx;
    logic [IDW:0]    cand;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic            grant;
    logic [KW-1:0]   gnt_key;
    logic [IDW:0]    ptr_inc;
    logic [IDW-1:0]  ptr_next;

    logic            push;
    logic            pop;
    logic [EW-1:0]   head;

    assign inflight   = {1'b0, iss_valid} + {1'b0, tag_valid};
    assign occupancy  = {1'b0, count} + {{(CW-1){1'b0}}, inflight};
    assign space      = occupancy < CW1'(DEPTH);
    assign fifo_empty = (count == '0);
    assign flush_eff  = flush_i && (state == ST_RUN);
    assign allow      = (state == ST_RUN) && space && !flush_i;

`ifdef CAM_HASH_ARB_PRIO0_EN
    // Requester 0 bypasses the ring; the others rotate among themselves.
    assign rr_valid = req_valid_i & ~REQ0_BIT;
    assign prio_hit = req_valid_i[0];
`else
    assign rr_valid = req_valid_i;
    assign prio_hit = 1'b0;
`endif

    // First valid requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + IDW1'(k);
            if (cand >= IDW1'(NREQ)) begin
                cand = cand - IDW1'(NREQ);
            end
            if (!rr_found && rr_valid[cand[IDW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[IDW-1:0];
            end
        end
    end

    assign gnt_found   = prio_hit || rr_found;
    assign gnt_idx     = prio_hit ? '0 : rr_idx;
    assign grant       = allow && gnt_found;
    assign req_ready_o = grant ? (REQ0_BIT << gnt_idx) : '0;

    always_comb begin
        gnt_key = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                gnt_key = req_key_i[i*KW +: KW];
            end
        end
    end

    always_comb begin
        ptr_inc  = {1'b0, gnt_idx} + IDW1'(1);
        ptr_next = ptr_inc[IDW-1:0];
        if (ptr_inc >= IDW1'(NREQ)) begin
            ptr_next = '0;
        end
    end

    // Results of killed ops and anything arriving during a flush are dropped.
    assign push = hash_valid_i && tag_valid && !tag_kill && !flush_eff;
    assign pop  = !fifo_empty && rsp_ready_i && !flush_eff;
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            ptr       <= '0;
            iss_valid <= 1'b0;
            iss_id    <= '0;
            calc_d    <= '0;
            tag_valid <= 1'b0;
            tag_kill  <= 1'b0;
            tag_id    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err       <= 1'b0;
            after_rst <= 1'b1;
        end else begin
            after_rst <= 1'b0;

            iss_valid <= grant;
            if (grant) begin
                iss_id <= gnt_idx;
                calc_d <= gnt_key;
                if (!prio_hit) begin
                    ptr <= ptr_next;
                end
            end

            tag_valid <= iss_valid;
            tag_id    <= iss_id;
            tag_kill  <= flush_eff;

            case (state)
                ST_RUN: begin
                    if (flush_i && (iss_valid || tag_valid)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!iss_valid && !tag_valid) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase

            if (flush_eff) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            // A result the cycle after reset belongs to an aborted op.
            if (hash_valid_i && !tag_valid && !after_rst) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tag_id, hash_i};
        end
    end

    assign calc_en_o   = iss_valid;
    assign calc_d_o    = calc_d;
    assign rsp_valid_o = !fifo_empty;
    assign rsp_id_o    = fifo_empty ? '0 : head[EW-1:HW];
    assign rsp_hash_o  = fifo_empty ? '0 : head[HW-1:0];
    assign err_o       = err;

endmodule

`default_nettype wire

// File: doc/cam_hash_arbiter.md
# cam_hash_arbiter

Round-robin scheduler that shares one CAM bank hash engine (19-bit key in, HW-bit hash out, registered, one-cycle latency) among NREQ lookup/insert requesters. It accepts keys over per-requester valid/ready, drives the hash engine's key and enable inputs, tags each in-flight operation with its requester ID, and returns `{id, hash}` through a response FIFO with valid/ready back-pressure. It sits between the CAM front-end request ports and the per-bank hash unit.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: requester ID width, equal to clog2(NREQ).
- `HW`, 5: hash width, matching the hash engine.
- `DEPTH`, 4: response FIFO entries, power of two and at least 2.
- `clk` input 1: clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid_i` input NREQ: per-requester key valid.
- `req_key_i` input NREQ*19: key of requester i at bits [19i+18:19i].
- `req_ready_o` output NREQ: one-hot grant/accept.
- `flush_i` input 1: discards queued and in-flight results.
- `calc_d_o` output 19: key to the hash engine.
- `calc_en_o` output 1: hash engine enable.
- `hash_i` input HW: hash engine result.
- `hash_valid_i` input 1: hash engine result valid.
- `rsp_valid_o` output 1: response valid.
- `rsp_ready_i` input 1: response accept.
- `rsp_id_o` output IDW: requester ID of the response.
- `rsp_hash_o` output HW: hash of the response.
- `err_o` output 1: sticky error; set by `hash_valid_i` arriving with nothing in flight.

## Operation
- **Reset values.** All outputs 0. RR pointer = 0. FIFO empty. FSM = RUN. In-flight tags cleared.
- **FSM states.** RUN and DRAIN.
  - RUN → DRAIN on `flush_i` when any op is in flight (issue register or hash engine).
  - RUN with `flush_i` and nothing in flight stays in RUN.
  - DRAIN → RUN once both in-flight slots are empty.
  - `flush_i` in DRAIN is a no-op.
- **Space rule.** `space = (fifo_count + inflight_count) < DEPTH`, where inflight_count is 0..2.
- **Grant.** In RUN, with `space` true and `flush_i` low, `req_ready_o` is one-hot on the first valid requester searching upward from the pointer, with wrap-around.
  - `req_ready_o` is combinational from `req_valid_i`, the pointer and state.
  - A requester's valid must not depend on its ready.
  - In DRAIN, or with `space` false, `req_ready_o` = 0.
- **Pointer update.** After a grant to i, pointer = (i+1) mod NREQ. The pointer is unchanged when there is no grant.
- **Issue stage.** The granted key and ID are registered. `calc_en_o` = 1 for exactly one cycle, with `calc_d_o` = key. `calc_d_o` holds its last value otherwise.
- **Tag pipeline.** The ID rides a one-deep tag register alongside the hash engine latency.
- **Result capture.** On `hash_valid_i`, `{tag, hash_i}` is written to the FIFO unless the op was flushed.
  - Flushed ops have a kill bit set in their tag slot, and their results are dropped.
- **FIFO.** Show-ahead. `rsp_valid_o` = !empty. The head is popped on `rsp_valid_o && rsp_ready_i`.
  - Push and pop in the same cycle keeps the count unchanged.
  - A push to a full FIFO cannot occur because of the space rule.
- **Flush.** Empties the FIFO in the same cycle, so `rsp_valid_o` = 0 next cycle. A pop in the flush cycle is ignored.
- **Error.** `hash_valid_i` with no live or killed tag sets `err_o`. The result is dropped. `err_o` clears only on `rst`.

## Timing
- **Latency.** Accept in cycle t → `calc_en_o` high in t+1 → `hash_valid_i` in t+2 → FIFO write at the end of t+2 → `rsp_valid_o` in t+3.
- **Throughput.** Sustained throughput is 1 op/cycle while `rsp_ready_i` = 1.
- **Back-pressure.** With `rsp_ready_i` = 0, at most DEPTH ops are accepted. The (DEPTH+1)th request stalls.
- **Reset.** `rst` mid-operation aborts all state within one cycle. Late `hash_valid_i` in the cycle after reset is discarded without setting `err_o`.

## Configuration
- **Macro:** `CAM_HASH_ARB_PRIO0_EN`.
- **Defined.** Requester 0 has strict priority: if `req_valid_i[0]` = 1 it is always granted, and the pointer is not updated. The other requesters use round-robin among themselves.
- **Undefined.** Pure round-robin across all NREQ requesters.

## Test plan
- **Single request.** After reset, requester 2 sends key 19'h1ABCD → `calc_en_o` pulses at t+1 with `calc_d_o` = 19'h1ABCD; `rsp_valid_o` is high at t+3 with `rsp_id_o` = 2 and `rsp_hash_o` = the engine model value.
- **Round-robin fairness.** All 4 requesters hold valid, `rsp_ready_i` = 1 → grants go 0,1,2,3,0,1… one per cycle, and responses come back in the same order. With `CAM_HASH_ARB_PRIO0_EN` defined → the grant sequence is 0,0,0….
- **Back-pressure.** `rsp_ready_i` = 0, continuous requests → exactly 4 accepts, then `req_ready_o` = 0. Raising `rsp_ready_i` drains the FIFO in order and then resumes grants.
- **Flush mid-flight.** Assert `flush_i` one cycle after an accept → FSM goes to DRAIN for 2 cycles with `req_ready_o` = 0; no response appears; `rsp_valid_o` = 0; after that, grants resume.
- **Spurious valid.** Pulse `hash_valid_i` while idle → `err_o` = 1 and stays set; FIFO stays empty; `rst` clears `err_o`.
- **Reset mid-operation.** Assert `rst` with 3 FIFO entries and 2 ops in flight → next cycle all outputs are 0 and the pointer is 0; the first grant after reset goes to the lowest valid requester.
